// File: rtl/gpio_ctrl_pkg.sv
// Shared definitions for the GPIO bank controller: bus register map,
// claim response layout and the cell register select.
package gpio_ctrl_pkg;

  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ID_W    = 5;
  localparam int unsigned PTR_W   = ID_W;
  localparam int unsigned CSEL_W  = 2;
  localparam int unsigned RSVD_W  = DATA_W - ID_W - 1;

  localparam logic [ADDR_W-1:0] VALUE      = 3'd0;
  localparam logic [ADDR_W-1:0] DIRECTION  = 3'd1;
  localparam logic [ADDR_W-1:0] INT_ENABLE = 3'd2;
  localparam logic [ADDR_W-1:0] PENDING    = 3'd3;
  localparam logic [ADDR_W-1:0] CLAIM      = 3'd4;

  typedef struct packed {
    logic              valid;
    logic [RSVD_W-1:0] reserved;
    logic [ID_W-1:0]   id;
  } claim_resp_t;

  typedef enum logic [CSEL_W-1:0] {
    CELL_VALUE      = 2'd0,
    CELL_DIRECTION  = 2'd1,
    CELL_INT_ENABLE = 2'd2
  } cell_reg_e;

endpackage

// File: rtl/rr_pending_selector.sv
// Round-robin pick: first set pending bit at or above the pointer,
// wrapping modulo GPIO_NUMBER.
module rr_pending_selector
  import gpio_ctrl_pkg::*;
#(
  parameter int unsigned GPIO_NUMBER = 8
) (
  input  logic [GPIO_NUMBER-1:0] pending_i,
  input  logic [PTR_W-1:0]       pointer_i,
  output logic                   valid_o,
  output logic [ID_W-1:0]        id_o
);

  logic [2*GPIO_NUMBER-1:0] doubled;
  logic [GPIO_NUMBER-1:0]   rot;
  logic                     found;
  logic [ID_W:0]            offset;
  logic [ID_W:0]            sum;

  // Rotate so bit 0 of rot is the pending bit at the pointer.
  assign doubled = {pending_i, pending_i} >> pointer_i;
  assign rot     = doubled[GPIO_NUMBER-1:0];

  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int unsigned k = 0; k < GPIO_NUMBER; k++) begin
      if (!found && rot[k]) begin
        found  = 1'b1;
        offset = (ID_W+1)'(k);
      end
    end
  end

  assign sum     = (ID_W+1)'(pointer_i) + offset;
  assign id_o    = (sum >= (ID_W+1)'(GPIO_NUMBER)) ? ID_W'(sum - (ID_W+1)'(GPIO_NUMBER))
                                                   : ID_W'(sum);
  assign valid_o = found;

endmodule

// File: rtl/gpio_bank_controller.sv
// Bus front end for a bank of single-pin gpio cells: register passthrough,
// edge-latched pending interrupts, round-robin CLAIM and aggregated interrupt.
module gpio_bank_controller
  import gpio_ctrl_pkg::*;
#(
  parameter int unsigned GPIO_NUMBER = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   write_i,
  input  logic [ADDR_W-1:0]      write_address_i,
  input  logic [DATA_W-1:0]      write_data_i,
  input  logic                   read_i,
  input  logic [ADDR_W-1:0]      read_address_i,
  output logic [DATA_W-1:0]      read_data_o,
  output logic                   read_valid_o,
  output logic [GPIO_NUMBER-1:0] gpio_write_o,
  output logic [CSEL_W-1:0]      gpio_write_address_o,
  output logic [GPIO_NUMBER-1:0] gpio_write_data_o,
  output logic [CSEL_W-1:0]      gpio_read_address_o,
  input  logic [GPIO_NUMBER-1:0] gpio_read_data_i,
  input  logic [GPIO_NUMBER-1:0] gpio_interrupt_i,
  output logic                   interrupt_o
);

  localparam logic [GPIO_NUMBER-1:0] ONE_HOT0 = GPIO_NUMBER'(1);

  logic [GPIO_NUMBER-1:0] pending_q, pending_d;
  logic [GPIO_NUMBER-1:0] prev_q;
  logic [GPIO_NUMBER-1:0] rise;
  logic [GPIO_NUMBER-1:0] clr_mask;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [ID_W:0]          id_inc;
  logic                   sel_valid;
  logic [ID_W-1:0]        sel_id;
  logic                   wr_cell;
  logic                   wr_pending;
  logic                   claim_fire;
  claim_resp_t            claim_resp;
  logic [DATA_W-1:0]      read_data_q, read_data_d;
  logic                   read_valid_q;
  logic                   interrupt_q;
  logic                   unused_wdata;

  // Upper data bits beyond the bank width carry no meaning.
  assign unused_wdata = ^write_data_i;

  // Cell register writes pass straight through in the request cycle.
  assign wr_cell              = write_i && (write_address_i <= INT_ENABLE);
  assign gpio_write_o         = wr_cell ? '1 : '0;
  assign gpio_write_address_o = write_i ? write_address_i[CSEL_W-1:0] : CELL_VALUE;
  assign gpio_write_data_o    = write_i ? write_data_i[GPIO_NUMBER-1:0] : '0;
  assign gpio_read_address_o  = read_address_i[CSEL_W-1:0];

  rr_pending_selector #(
    .GPIO_NUMBER (GPIO_NUMBER)
  ) u_sel (
    .pending_i (pending_q),
    .pointer_i (ptr_q),
    .valid_o   (sel_valid),
    .id_o      (sel_id)
  );

  assign wr_pending = write_i && (write_address_i == PENDING);
  assign claim_fire = read_i && (read_address_i == CLAIM) && sel_valid;

  always_comb begin
    claim_resp          = '0;
    claim_resp.valid    = sel_valid;
    claim_resp.reserved = '0;
    claim_resp.id       = sel_valid ? sel_id : '0;
  end

  // New rising edges are OR-ed in after clears so a coincident set wins.
  always_comb begin
    rise     = gpio_interrupt_i & ~prev_q;
    clr_mask = '0;
    if (wr_pending) begin
      clr_mask = clr_mask | write_data_i[GPIO_NUMBER-1:0];
    end
    if (claim_fire) begin
      clr_mask = clr_mask | (ONE_HOT0 << sel_id);
    end
    pending_d = (pending_q & ~clr_mask) | rise;
  end

  always_comb begin
    id_inc = {1'b0, sel_id} + (ID_W+1)'(1);
    ptr_d  = ptr_q;
    if (claim_fire) begin
      ptr_d = (id_inc >= (ID_W+1)'(GPIO_NUMBER)) ? '0 : id_inc[ID_W-1:0];
    end
  end

  // Read response source; pending is sampled before any same-cycle update.
  always_comb begin
    read_data_d = read_data_q;
    if (read_i) begin
      case (read_address_i)
        VALUE, DIRECTION, INT_ENABLE: read_data_d = DATA_W'(gpio_read_data_i);
        PENDING:                      read_data_d = DATA_W'(pending_q);
        CLAIM:                        read_data_d = claim_resp;
        default:                      read_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending_q    <= '0;
      prev_q       <= '0;
      ptr_q        <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      interrupt_q  <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      prev_q       <= gpio_interrupt_i;
      ptr_q        <= ptr_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_i;
      interrupt_q  <= |pending_q;
    end
  end

  assign read_data_o  = read_data_q;
  assign read_valid_o = read_valid_q;
  assign interrupt_o  = interrupt_q;

endmodule
